redirect_ctrl: RTL
==================

# redirect_ctrl

Forwarding and load-use hazard controller for the five-stage pipeline's operand datapath. It tracks destination-register information for the EX, MEM and WB stages and drives the 2-bit select and enable of the two 4-input operand multiplexers (A and B) in the ID stage. It stalls IF/ID and injects a bubble into EX for one cycle on a load-use hazard, and keeps a saturating stall-cycle counter for performance debug.

## Interface
- `RW`, default 5: register address width.
- `CW`, default 16: stall counter width.

- `clk`  in  1: pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `id_rs`, `id_rt`  in  RW: source register numbers of the instruction in ID.
- `id_rs_used`, `id_rt_used`  in  1: that source is actually read.
- `id_wr_reg`  in  RW: destination register of the instruction in ID.
- `id_reg_write`  in  1: ID instruction writes the register file.
- `id_mem_read`  in  1: ID instruction is a load.
- `flush`  in  1: ID instruction is killed (taken branch/jump); it enters EX as a bubble.
- `halt`  in  1: whole pipeline frozen; no tracking state changes.
- `fwd_a_sel`, `fwd_b_sel`  out  2: operand mux select. 00 = register file, 01 = EX ALU result, 10 = MEM result, 11 = WB write data.
- `fwd_a_zero`, `fwd_b_zero`  out  1: operand mux enable. 1 forces the mux output to 0.
- `stall`  out  1: hold PC and IF/ID; bubble into EX.
- `stall_cnt`  out  CW: saturating count of stall cycles.

## Operation
- Stage slots EX, MEM and WB each hold `v` (write valid) and `rd`. EX also holds `ld` (load).
- `v` is set only when `reg_write`=1 and `rd`!=0. Register 0 is never a forwarding source.
- Forwarding for operand A (B is identical, using `id_rt`/`id_rt_used`):
  - If `id_rs_used`=0: select 00 and zero=1.
  - Otherwise, zero=0. Select 01 if EX.v and EX.rd==`id_rs` and !EX.ld.
  - Else 10 if MEM.v and MEM.rd matches.
  - Else 11 if WB.v and WB.rd matches.
  - Else 00.
  - Priority is EX > MEM > WB (youngest wins).
- Load-use: `hazard` = EX.v & EX.ld & ((`id_rs_used` & EX.rd==`id_rs`) | (`id_rt_used` & EX.rd==`id_rt`)).
- `stall` = `hazard` & !`flush`. A flushed instruction never stalls.
- While `hazard` is asserted, a source matching EX.rd selects 00. The value is don't-care because the instruction is stalled.
- Advance when `halt`=0:
  - WB <= MEM, and MEM <= EX (the `ld` flag is dropped).
  - EX <= bubble (v=0, ld=0) if `stall` or `flush`.
  - Otherwise EX <= {`id_reg_write` & `id_wr_reg`!=0, `id_wr_reg`, `id_mem_read`}.
- When `halt`=1, the EX/MEM/WB slots and `stall_cnt` hold. Outputs remain combinational from the current state.
- `stall_cnt` increments on each clock edge where `stall`=1 and `halt`=0. It saturates at 2^CW−1 and does not wrap.
- After a load-use stall, the load sits in MEM on the next cycle. The dependent instruction then gets select 10, since the MEM result is the load data.

## Timing
- `fwd_*_sel`, `fwd_*_zero` and `stall` are combinational from the ID inputs and the registered stage slots, with zero-cycle latency.
- A load-use stall lasts exactly 1 cycle (absent `halt`). If `halt` is asserted during it, the stall extends until the advancing edge.
- Reset (async, on the `rst_n` falling edge) does the following:
  - All slots become v=0, ld=0, rd=0, and `stall_cnt` becomes 0.
  - With a valid ID instruction, the outputs are therefore `stall`=0 and select 00, with zero = !used.
- Reset mid-stall clears the stall immediately; no state is retained.
- Simultaneous cases:
  - `flush` and `hazard` together: bubble enters EX, `stall`=0, counter unchanged.
  - `halt` with anything: no state change.
  - EX and MEM both matching: 01, or for an EX load: stall, then 10.
- Both operands may forward from different stages in the same cycle.

## Test plan
- Reset, then ID reads r3 with no writers in flight -> A/B select 00, `stall`=0, `stall_cnt`=0.
- `add r5` followed by `sub` reading r5 as rs -> next cycle `fwd_a_sel`=01. One cycle later MEM match -> 10, then WB -> 11, then 00.
- `lw r7` followed by an instruction using r7 as rt -> `stall`=1 for one cycle, `stall_cnt`=1. Next cycle `fwd_b_sel`=10 and `stall`=0.
- Writer to r0 followed by a reader of r0 -> select 00. An unused rt that matches EX.rd -> `fwd_b_zero`=1, select 00, no stall.
- Load-use hazard with `flush`=1 -> `stall`=0 and EX gets a bubble. Hazard with `halt`=1 for 3 cycles -> `stall` held for 4 cycles and `stall_cnt` +1.
- Force 2^16 stall cycles -> `stall_cnt` saturates at 0xFFFF. Assert `rst_n`=0 mid-stall -> `stall`=0 and counter 0 immediately.

Source files
------------

// File: rtl/redirect_ctrl.sv
// Operand forwarding and load-use hazard control for the five-stage pipeline.
// Tracks EX/MEM/WB destination info and drives the ID-stage operand mux selects.
module redirect_ctrl #(
    parameter int RW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_rs_used,
    input  logic          id_rt_used,
    input  logic [RW-1:0] id_wr_reg,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          flush,
    input  logic          halt,
    output logic [1:0]    fwd_a_sel,
    output logic [1:0]    fwd_b_sel,
    output logic          fwd_a_zero,
    output logic          fwd_b_zero,
    output logic          stall,
    output logic [CW-1:0] stall_cnt
);

    logic          ex_v;
    logic          ex_ld;
    logic [RW-1:0] ex_rd;
    logic          mem_v;
    logic [RW-1:0] mem_rd;
    logic          wb_v;
    logic [RW-1:0] wb_rd;
    logic          hazard;

    // A load in EX cannot be forwarded yet; its match selects 00 (the instruction stalls).
    function automatic logic [1:0] fwd_sel(
        input logic [RW-1:0] src,
        input logic          used,
        input logic          e_v,
        input logic          e_ld,
        input logic [RW-1:0] e_rd,
        input logic          m_v,
        input logic [RW-1:0] m_rd,
        input logic          w_v,
        input logic [RW-1:0] w_rd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (used) begin
            if (e_v && e_rd == src)
                sel = e_ld ? 2'b00 : 2'b01;
            else if (m_v && m_rd == src)
                sel = 2'b10;
            else if (w_v && w_rd == src)
                sel = 2'b11;
        end
        return sel;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        logic [CW-1:0] r;
        r = (c == {CW{1'b1}}) ? c : c + CW'(1);
        return r;
    endfunction

    always_comb begin
        fwd_a_sel  = fwd_sel(id_rs, id_rs_used, ex_v, ex_ld, ex_rd, mem_v, mem_rd, wb_v, wb_rd);
        fwd_b_sel  = fwd_sel(id_rt, id_rt_used, ex_v, ex_ld, ex_rd, mem_v, mem_rd, wb_v, wb_rd);
        fwd_a_zero = ~id_rs_used;
        fwd_b_zero = ~id_rt_used;
        hazard     = ex_v & ex_ld & ((id_rs_used & (ex_rd == id_rs)) |
                                     (id_rt_used & (ex_rd == id_rt)));
        stall      = hazard & ~flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v      <= 1'b0;
            ex_ld     <= 1'b0;
            ex_rd     <= '0;
            mem_v     <= 1'b0;
            mem_rd    <= '0;
            wb_v      <= 1'b0;
            wb_rd     <= '0;
            stall_cnt <= '0;
        end else if (!halt) begin
            wb_v   <= mem_v;
            wb_rd  <= mem_rd;
            mem_v  <= ex_v;
            mem_rd <= ex_rd;
            if (stall || flush) begin
                ex_v  <= 1'b0;
                ex_ld <= 1'b0;
                ex_rd <= '0;
            end else begin
                ex_v  <= id_reg_write & (id_wr_reg != '0);
                ex_ld <= id_mem_read;
                ex_rd <= id_wr_reg;
            end
            if (stall)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule
